// File: rtl/dmuxn_reg.sv
// Registered N-way word demultiplexer with per-channel one-entry holding
// registers, valid/ready handshake on both sides, broadcast mode and a transfer counter.
module dmuxn_reg #(
    parameter int WIDTH    = 16,
    parameter int WAYS     = 4,
    localparam int SEL_BITS = $clog2(WAYS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [WIDTH-1:0]        in,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SEL_BITS-1:0]     sel,
    input  logic                    bcast,
    output logic [WAYS*WIDTH-1:0]   out,
    output logic [WAYS-1:0]         out_valid,
    input  logic [WAYS-1:0]         out_ready,
    output logic [15:0]             count
);

    logic [WAYS-1:0]  out_valid_reg;
    logic [WAYS-1:0]  free;
    logic [WAYS-1:0]  load;
    logic             accept;
    logic [15:0]      count_reg;

    // A slot draining this edge is free, giving one word per cycle per channel.
    assign free     = ~out_valid_reg | out_ready;
    assign in_ready = !reset && (bcast ? (&free) : free[sel]);
    assign accept   = in_valid && in_ready;

    generate
        for (genvar gi = 0; gi < WAYS; gi++) begin : g_chan
            logic [WIDTH-1:0] data_reg;

            assign load[gi] = accept && (bcast || (sel == SEL_BITS'(gi)));

            always_ff @(posedge clk) begin
                if (reset) begin
                    data_reg          <= '0;
                    out_valid_reg[gi] <= 1'b0;
                end else if (load[gi]) begin
                    data_reg          <= in;
                    out_valid_reg[gi] <= 1'b1;
                end else if (out_ready[gi]) begin
                    out_valid_reg[gi] <= 1'b0;
                end
            end

            assign out[gi*WIDTH +: WIDTH] = data_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
        end else if (accept) begin
            count_reg <= count_reg + 16'd1;
        end
    end

    assign out_valid = out_valid_reg;
    assign count     = count_reg;

endmodule

// File: tb/tb_dmuxn_reg.sv
// Directed bench for dmuxn_reg: reset, unicast, back-to-back, broadcast stall,
// mid-stream reset and counter wrap.
module tb_dmuxn_reg;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] in;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  sel;
    logic        bcast;
    logic [63:0] out;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [15:0] count;

    int checks = 0;
    int errs   = 0;

    dmuxn_reg #(.WIDTH(16), .WAYS(4)) dut (
        .clk(clk), .reset(reset), .in(in), .in_valid(in_valid), .in_ready(in_ready),
        .sel(sel), .bcast(bcast), .out(out), .out_valid(out_valid),
        .out_ready(out_ready), .count(count)
    );

    always #5 clk = ~clk;

    // Advance one rising edge; inputs change and outputs are sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0; bcast = 1'b0; sel = 2'd0; in = 16'h0; out_ready = 4'b0;
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b1; bcast = 1'b0; sel = 2'd0; in = 16'h1234; out_ready = 4'b0;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errs++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        else $display("ok reset_in_ready");
        tick();
        reset = 1'b0; in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 4'b0000) begin errs++; $display("FAIL reset_valid got=%b exp=0000", out_valid); end
        else $display("ok reset_valid");
        checks++;
        if (count !== 16'd0) begin errs++; $display("FAIL reset_count got=%0d exp=0", count); end
        else $display("ok reset_count");
        checks++;
        if (out !== 64'h0) begin errs++; $display("FAIL reset_out got=%h exp=0", out); end
        else $display("ok reset_out");
        checks++;
        if (in_ready !== 1'b1) begin errs++; $display("FAIL idle_in_ready got=%b exp=1", in_ready); end
        else $display("ok idle_in_ready");
    endtask

    task automatic test_unicast_sweep();
        logic [3:0] exp_v;
        do_reset();
        in = 16'hA5A5; in_valid = 1'b1; bcast = 1'b0; out_ready = 4'b0;
        exp_v = 4'b0000;
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            #1;
            checks++;
            if (in_ready !== 1'b1) begin errs++; $display("FAIL sweep_ready sel=%0d got=%b exp=1", s, in_ready); end
            tick();
            exp_v[s] = 1'b1;
            checks++;
            if (out_valid !== exp_v) begin errs++; $display("FAIL sweep_valid sel=%0d got=%b exp=%b", s, out_valid, exp_v); end
            else $display("ok sweep sel=%0d valid=%b", s, out_valid);
        end
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (out[c*16 +: 16] !== 16'hA5A5) begin errs++; $display("FAIL sweep_data ch=%0d got=%h exp=a5a5", c, out[c*16 +: 16]); end
        end
        checks++;
        if (count !== 16'd4) begin errs++; $display("FAIL sweep_count got=%0d exp=4", count); end
        else $display("ok sweep_count");
        sel = 2'd2; in = 16'h7777;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errs++; $display("FAIL sweep_full_ready got=%b exp=0", in_ready); end
        else $display("ok sweep_full_blocked");
        tick();
        in_valid = 1'b0;
        checks++;
        if (count !== 16'd4 || out[32 +: 16] !== 16'hA5A5) begin
            errs++; $display("FAIL sweep_no_load count=%0d ch2=%h exp count=4 ch2=a5a5", count, out[32 +: 16]);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        out_ready = 4'b0010; bcast = 1'b0; sel = 2'd1; in_valid = 1'b1;
        for (int w = 1; w <= 3; w++) begin
            in = 16'(w);
            tick();
            checks++;
            if (out_valid[1] !== 1'b1 || out[16 +: 16] !== 16'(w)) begin
                errs++; $display("FAIL b2b word=%0d valid=%b data=%h exp valid=1 data=%h", w, out_valid[1], out[16 +: 16], 16'(w));
            end else $display("ok b2b word=%0d", w);
        end
        checks++;
        if (count !== 16'd3) begin errs++; $display("FAIL b2b_count got=%0d exp=3", count); end
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 4'b0000) begin errs++; $display("FAIL b2b_drain got=%b exp=0000", out_valid); end
        else $display("ok b2b_drain");
        out_ready = 4'b0;
    endtask

    task automatic test_bcast_stall();
        do_reset();
        out_ready = 4'b0; bcast = 1'b0; sel = 2'd3; in = 16'h0033; in_valid = 1'b1;
        tick();
        bcast = 1'b1; in = 16'h0042; sel = 2'd0;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errs++; $display("FAIL bcast_stall_ready got=%b exp=0", in_ready); end
        else $display("ok bcast_stalled");
        tick();
        checks++;
        if (out_valid !== 4'b1000 || out[48 +: 16] !== 16'h0033 || count !== 16'd1) begin
            errs++; $display("FAIL bcast_stall_hold valid=%b ch3=%h count=%0d exp 1000/0033/1", out_valid, out[48 +: 16], count);
        end
        out_ready = 4'b1000;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errs++; $display("FAIL bcast_go_ready got=%b exp=1", in_ready); end
        tick();
        out_ready = 4'b0; in_valid = 1'b0; bcast = 1'b0;
        checks++;
        if (out_valid !== 4'b1111) begin errs++; $display("FAIL bcast_valid got=%b exp=1111", out_valid); end
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (out[c*16 +: 16] !== 16'h0042) begin errs++; $display("FAIL bcast_data ch=%0d got=%h exp=0042", c, out[c*16 +: 16]); end
        end
        checks++;
        if (count !== 16'd2) begin errs++; $display("FAIL bcast_count got=%0d exp=2", count); end
        else $display("ok bcast delivered");
    endtask

    task automatic test_reset_midstream();
        reset = 1'b1; in_valid = 1'b1; bcast = 1'b0; sel = 2'd0; in = 16'hBEEF; out_ready = 4'b0;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errs++; $display("FAIL mid_reset_ready got=%b exp=0", in_ready); end
        tick();
        reset = 1'b0; in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 4'b0000 || out !== 64'h0 || count !== 16'd0) begin
            errs++; $display("FAIL mid_reset valid=%b out=%h count=%0d exp all zero", out_valid, out, count);
        end else $display("ok mid_reset");
    endtask

    task automatic test_count_wrap();
        do_reset();
        out_ready = 4'b1111; bcast = 1'b0; sel = 2'd0; in = 16'h5555; in_valid = 1'b1;
        for (int n = 0; n < 65536; n++) tick();
        checks++;
        if (count !== 16'd0) begin errs++; $display("FAIL wrap_zero got=%0d exp=0", count); end
        else $display("ok wrap to 0");
        tick();
        in_valid = 1'b0;
        checks++;
        if (count !== 16'd1) begin errs++; $display("FAIL wrap_one got=%0d exp=1", count); end
        else $display("ok wrap then 1");
    endtask

    initial begin
        reset = 1'b1; in = '0; in_valid = 1'b0; sel = '0; bcast = 1'b0; out_ready = '0;
        #2;
        test_reset();
        test_unicast_sweep();
        test_back_to_back();
        test_bcast_stall();
        test_reset_midstream();
        test_count_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
        $finish;
    end

endmodule

// File: doc/dmuxn_reg.md
# dmuxn_reg

Parametrised, registered N-way demultiplexer for word streams: a generalised, clocked successor to the fixed 4-way single-bit demux. Each input word is routed by `sel` to one of `WAYS` output channels, or to all channels at once in broadcast mode. Every channel has a one-entry holding register with a valid/ready handshake. The block sits between a word producer (CPU/ALU-side bus) and multiple consumers (memory-mapped peripherals, screen/keyboard ports). Its accepted-transfer counter is used for debug.

## Interface

Parameters:
- `WIDTH`, 16, data word width in bits (≥1).
- `WAYS`, 4, number of output channels; power of two, ≥2.
- `SEL_BITS` (localparam), `$clog2(WAYS)`, width of `sel`.

Ports:
- `clk`  input  1  single clock; all state updates on rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `in`  input  WIDTH  input data word.
- `in_valid`  input  1  `in`/`sel`/`bcast` are valid this cycle.
- `in_ready`  output  1  block accepts the word this cycle (combinational).
- `sel`  input  SEL_BITS  target channel index (ignored when `bcast`=1).
- `bcast`  input  1  1 = deliver the word to every channel.
- `out`  output  WAYS*WIDTH  channel data; channel i is at bits [i*WIDTH +: WIDTH].
- `out_valid`  output  WAYS  per-channel holding register full.
- `out_ready`  input  WAYS  per-channel consumer accepts.
- `count`  output  16  number of accepted input transfers, wrapping.

## Operation

- Channel i has one holding register (`data_i`, `out_valid[i]`). `out` is always driven from the registers, never combinationally from `in`.
- Slot free: `free[i] = !out_valid[i] || out_ready[i]`. A channel draining this cycle counts as free, so back-to-back throughput is 1 word/cycle per channel.
- `in_ready`:
  - 0 while `reset`=1.
  - When `bcast`=1: AND of `free[i]` over all i.
  - When `bcast`=0: `free[sel]`.
  - Depends on `sel`/`bcast` even when `in_valid`=0.
- Input transfer: `in_valid && in_ready` at a rising edge.
  - Unicast: channel `sel` loads `in` and sets valid.
  - Broadcast: every channel loads `in` and sets valid.
  - Non-target channels are untouched.
- Output transfer on channel i: `out_valid[i] && out_ready[i]` at an edge. It clears `out_valid[i]` unless that same edge also loads channel i, in which case valid stays 1 and the data becomes the new word.
- `out_ready[i]` when `out_valid[i]`=0 has no effect.
- Data in a holding register stays stable while `out_valid[i]`=1 and `out_ready[i]`=0.
- `count` increments by 1 per input transfer (a broadcast counts once). It wraps 16'hFFFF→0.
- No word is ever dropped or duplicated on a channel. A broadcast is all-or-nothing: it never partially delivers.

## Timing

- Reset (synchronous): on any edge with `reset`=1, all `out_valid`=0, all `out` words=0, `count`=0. `in_ready`=0 for the whole reset cycle.
- Reset asserted mid-stream discards held words. A transfer presented in the reset cycle is not accepted.
- Latency: a word accepted at edge k appears on `out` with `out_valid`=1 immediately after edge k (1 cycle).
- Simultaneous load and drain on the same channel at edge k: old word consumed, new word held, `out_valid` stays 1.
- A broadcast stalls (`in_ready`=0) while any channel is full and not draining. It proceeds on the first cycle all channels are free.
- Unicast to a free channel is never blocked by other full channels.

## Test plan

- Reset, then idle with `out_ready`=0 -> `out_valid`=4'b0000, `count`=0, `in_ready`=1. In the reset cycle itself, `in_ready`=0.
- Unicast sweep with `in`=16'hA5A5, `in_valid`=1, `sel`=0..3 one per cycle, `out_ready`=0 -> after each edge exactly one additional `out_valid` bit sets (0001, 0011, 0111, 1111), each word = 16'hA5A5, `count`=4. A further `sel`=2 word sees `in_ready`=0.
- Back-to-back on channel 1 with `out_ready[1]`=1 and words 1, 2, 3 on consecutive cycles -> `out_valid[1]` stays 1. Channel 1 shows 1, 2, 3 on successive cycles. `count`=3.
- Broadcast stall: channel 3 full with `out_ready[3]`=0, then `bcast`=1, `in`=16'h0042 -> `in_ready`=0 and nothing loads. Raising `out_ready[3]` for one cycle -> all four channels hold 16'h0042 next cycle, `count` +1.
- Reset mid-stream with all channels full -> next cycle `out_valid`=0, `out`=0, `count`=0. The input word presented during reset is not delivered.
- Counter wrap: 65536 accepted transfers -> `count` returns to 0. The 65537th transfer gives `count`=1.
